mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sequences the single shared memory bus (o_memaddr / o_memread / bidirectional b_membus) between two requesters in the cpu:
  - the instruction-fetch port (IF), read-only;
  - the data port (DM), read/write with byte enables.
- Grants one transaction at a time and drives the bus protocol.
- Performs read-modify-write for sub-word stores, since the memory only accepts whole words.
- Sits between the cpu core and the memory model.

Parameters:
- RESET_ADDR, 32'h8000_0000, value parked on o_memaddr at reset and when idle.
- MAX_DM_STREAK, 4, consecutive DM grants allowed while IF is waiting before IF is forced through (range 1..15).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  reset, synchronous and active-high.
- i_if_req  in  1  IF request valid.
- i_if_addr  in  32  IF byte address (bits [1:0] ignored).
- o_if_gnt  out  1  IF request accepted this cycle.
- o_if_valid  out  1  one-cycle pulse, o_if_rdata valid.
- o_if_rdata  out  32  fetched word.
- i_dm_req  in  1  DM request valid.
- i_dm_we  in  1  1 = store, 0 = load.
- i_dm_addr  in  32  DM byte address (bits [1:0] ignored for the bus).
- i_dm_be  in  4  byte enables for stores (lane 0 = bits [7:0]); ignored for loads.
- i_dm_wdata  in  32  store data, lane-aligned.
- o_dm_gnt  out  1  DM request accepted this cycle.
- o_dm_valid  out  1  one-cycle completion pulse; for loads, o_dm_rdata is valid.
- o_dm_rdata  out  32  loaded word (full word; the core extracts bytes).
- o_memaddr  out  32  word-aligned bus address: {addr[31:2], 2'b00}.
- o_memread  out  1  1 = memory drives b_membus with mem[o_memaddr]; 0 = arbiter drives b_membus.
- b_membus  inout  32  shared data bus.

Behaviour:
- Bus contract:
  - Memory drives b_membus combinationally while o_memread = 1.
  - Memory commits b_membus to o_memaddr on each 1->0 transition of o_memread.
  - Arbiter drives b_membus only while o_memread = 0, otherwise 'z.
  - o_memread = 0 occurs only in WR.
- Reset values: state IDLE, o_memread = 1, o_memaddr = RESET_ADDR, gnt/valid = 0, rdata = 0, streak = 0.
- Reset mid-transaction aborts it with no valid pulse. If reset hits in WR, the write has already been committed; this is acceptable.
- Request handshake:
  - A request is accepted when req && gnt in the same cycle.
  - gnt is combinational and asserted only in IDLE; at most one gnt per cycle.
  - Request fields are latched at acceptance.
  - A requester may hold req high to issue its next transaction.
- Arbitration in IDLE:
  - DM wins unless IF is requesting and streak == MAX_DM_STREAK.
  - streak increments on each DM grant while i_if_req = 1, and clears on any IF grant or when i_if_req = 0.
- FSM states and transitions (cycle 0 = acceptance):
  - IDLE -> RD on a load or fetch; -> WR on a store with be = 4'hF; -> RMW_RD on a store with any other non-zero be; -> IDLE on a store with be = 0, with valid next cycle and no bus activity.
  - RD: o_memaddr = latched address, o_memread = 1. The bus is captured into rdata at the end of the cycle. -> IDLE; valid is high in cycle 2.
  - RMW_RD: same as RD, but the captured word is merged with wdata per be into a write buffer. -> WR.
  - WR: o_memread = 0, b_membus = write buffer. -> IDLE; valid is high the following cycle.
  - IDLE: o_memread = 1, o_memaddr holds the last address.
- Latency: read 2 cycles; full-word store 2 cycles; sub-word store 3 cycles.
- Back-to-back: a new grant may coincide with the previous valid pulse (zero bubble).
- rdata holds its value between valids.
- The valid pulse goes only to the port that owned the transaction.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, RD, RMW_RD, WR};
  - owner enum {OWN_IF, OWN_DM};
  - BE_FULL = 4'hF;
  - default RESET_ADDR.
- One combinational sub-module, be_merge: (old word, new word, be) -> merged word.

Test Plan:
- Reset held 3 cycles, then released -> o_memread = 1, o_memaddr = 32'h8000_0000, no gnt/valid until a request arrives.
- IF read of 0x8000_0010 with mem word 0x00500093 -> o_if_gnt in cycle 0, o_memaddr = 0x8000_0010 in cycle 1, o_if_valid with rdata 0x00500093 in cycle 2.
- DM store addr 0x8000_2004, be = F, wdata 0xDEADBEEF -> o_memread low for exactly 1 cycle; a following load returns 0xDEADBEEF.
- DM store addr 0x8000_2005, be = 4'b0010, wdata 0x0000AA00 over old word 0x11223344 -> RD, then WR of 0x1122AA44; o_dm_valid in cycle 3.
- IF and DM both requesting continuously, MAX_DM_STREAK = 4 -> grant sequence DM, DM, DM, DM, IF, DM, ...; IF is never starved.
- Reset asserted during RMW_RD -> next cycle is IDLE, no valid pulse, no 1->0 edge on o_memread, memory unchanged.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    RMW_RD,
    WR
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_t;

  localparam logic [3:0]  BE_FULL            = 4'hF;
  localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h8000_0000;
  localparam logic [31:0] WORD_MASK          = 32'hFFFF_FFFC;

  // Memory is word-addressed on the bus; drop the byte offset.
  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side handshake bundle: instruction-fetch port and data port.
interface mem_arbiter_if;

  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt;
  logic        o_if_valid;
  logic [31:0] o_if_rdata;

  logic        i_dm_req;
  logic        i_dm_we;
  logic [31:0] i_dm_addr;
  logic [3:0]  i_dm_be;
  logic [31:0] i_dm_wdata;
  logic        o_dm_gnt;
  logic        o_dm_valid;
  logic [31:0] o_dm_rdata;

  // The cpu core side issues requests.
  modport master (
    output i_if_req, i_if_addr,
    input  o_if_gnt, o_if_valid, o_if_rdata,
    output i_dm_req, i_dm_we, i_dm_addr, i_dm_be, i_dm_wdata,
    input  o_dm_gnt, o_dm_valid, o_dm_rdata
  );

  // The arbiter side answers them.
  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_gnt, o_if_valid, o_if_rdata,
    input  i_dm_req, i_dm_we, i_dm_addr, i_dm_be, i_dm_wdata,
    output o_dm_gnt, o_dm_valid, o_dm_rdata
  );

endinterface

// File: rtl/mem_arbiter_be_merge.sv
// Byte-lane merge: lanes with be set take the new word, others keep the old.
module be_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  be,
  output logic [31:0] merged
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      // One byte lane select per enable bit.
      assign merged[gi*8 +: 8] = be[gi] ? new_word[gi*8 +: 8] : old_word[gi*8 +: 8];
    end
  endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single shared memory bus between instruction fetch and
// data access, with read-modify-write for partial-word stores.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR    = DEFAULT_RESET_ADDR,
  parameter int unsigned MAX_DM_STREAK = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  mem_arbiter_if.slave     bus,
  output logic [31:0]      o_memaddr,
  output logic             o_memread,
  inout  wire  [31:0]      b_membus
);

  localparam logic [3:0] STREAK_LIMIT = 4'(MAX_DM_STREAK);

  state_t      state_reg;
  owner_t      owner_reg;
  logic [3:0]  be_reg;
  logic [31:0] wdata_reg;
  logic [31:0] wbuf_reg;
  logic [31:0] memaddr_reg;
  logic        memread_reg;
  logic        if_valid_reg;
  logic        dm_valid_reg;
  logic [31:0] if_rdata_reg;
  logic [31:0] dm_rdata_reg;
  logic [3:0]  streak_reg;

  logic        idle;
  logic        streak_full;
  logic        dm_gnt;
  logic        if_gnt;
  logic [31:0] merged_word;

  // Grants are only offered from IDLE; DM wins unless IF has waited too long.
  always_comb begin
    idle        = (state_reg == IDLE) && !i_reset;
    streak_full = (streak_reg == STREAK_LIMIT);
    dm_gnt      = idle && bus.i_dm_req && !(bus.i_if_req && streak_full);
    if_gnt      = idle && bus.i_if_req && !dm_gnt;
  end

  be_merge u_be_merge (
    .old_word (b_membus),
    .new_word (wdata_reg),
    .be       (be_reg),
    .merged   (merged_word)
  );

  // Bus transaction FSM with registered bus controls and response outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg    <= IDLE;
      owner_reg    <= OWN_IF;
      be_reg       <= 4'h0;
      wdata_reg    <= 32'h0;
      wbuf_reg     <= 32'h0;
      memaddr_reg  <= RESET_ADDR;
      memread_reg  <= 1'b1;
      if_valid_reg <= 1'b0;
      dm_valid_reg <= 1'b0;
      if_rdata_reg <= 32'h0;
      dm_rdata_reg <= 32'h0;
      streak_reg   <= 4'h0;
    end else begin
      if_valid_reg <= 1'b0;
      dm_valid_reg <= 1'b0;

      // Count DM grants that overtook a waiting fetch.
      if (if_gnt || !bus.i_if_req) begin
        streak_reg <= 4'h0;
      end else if (dm_gnt) begin
        streak_reg <= streak_reg + 4'd1;
      end

      case (state_reg)
        IDLE: begin
          if (dm_gnt) begin
            owner_reg   <= OWN_DM;
            memaddr_reg <= word_addr(bus.i_dm_addr);
            be_reg      <= bus.i_dm_be;
            wdata_reg   <= bus.i_dm_wdata;
            wbuf_reg    <= bus.i_dm_wdata;
            if (!bus.i_dm_we) begin
              state_reg <= RD;
            end else if (bus.i_dm_be == BE_FULL) begin
              state_reg   <= WR;
              memread_reg <= 1'b0;
            end else if (bus.i_dm_be != 4'h0) begin
              state_reg <= RMW_RD;
            end else begin
              // Empty store: nothing to touch, just acknowledge.
              dm_valid_reg <= 1'b1;
            end
          end else if (if_gnt) begin
            owner_reg   <= OWN_IF;
            memaddr_reg <= word_addr(bus.i_if_addr);
            state_reg   <= RD;
          end
        end

        RD: begin
          if (owner_reg == OWN_IF) begin
            if_rdata_reg <= b_membus;
            if_valid_reg <= 1'b1;
          end else begin
            dm_rdata_reg <= b_membus;
            dm_valid_reg <= 1'b1;
          end
          state_reg <= IDLE;
        end

        RMW_RD: begin
          // Old word is on the bus now; fold in the enabled store lanes.
          wbuf_reg    <= merged_word;
          memread_reg <= 1'b0;
          state_reg   <= WR;
        end

        WR: begin
          // The falling edge of memread already committed the write.
          memread_reg  <= 1'b1;
          dm_valid_reg <= 1'b1;
          state_reg    <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign b_membus       = memread_reg ? 32'bz : wbuf_reg;
  assign o_memaddr      = memaddr_reg;
  assign o_memread      = memread_reg;
  assign bus.o_if_gnt   = if_gnt;
  assign bus.o_dm_gnt   = dm_gnt;
  assign bus.o_if_valid = if_valid_reg;
  assign bus.o_dm_valid = dm_valid_reg;
  assign bus.o_if_rdata = if_rdata_reg;
  assign bus.o_dm_rdata = dm_rdata_reg;

endmodule
